bcd_down_counter: RTL and testbench

BCD_DOWN_COUNTER -- requirements
Module: bcd_down_counter

---
 rtl/bcd_pkg.sv | 23 ++
 rtl/bcd_down_counter_if.sv | 36 +++
 rtl/bcd_digit_dec.sv | 29 ++
 rtl/bcd_down_counter.sv | 126 ++++++++++++
 tb/tb_bcd_down_counter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD down counter.
//   bcd_digit_t : one packed BCD digit (0..9 legal, 10..15 illegal)
//   BCD_MAX     : largest legal BCD digit value
//   state_t     : counter control states
//   is_bcd()    : true when a 4-bit value is a legal BCD digit
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic is_bcd(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_down_counter_if.sv
// Control/status bundle of the BCD down counter.
//   Requests (master -> slave): load, load_ten, load_one, start, pause, en
//   Status   (slave -> master): count_ten, count_one, busy, done, err, state
//
// Handshake: there is no valid/ready pair. Every request is a level that is
// sampled on each rising clk edge and always consumed at that edge; the slave
// never back-pressures. A load is either accepted (err low next cycle) or
// rejected (err high next cycle) at the edge it is seen. 'state' is a debug
// view of the control FSM for checkers.
interface bcd_down_counter_if;
  import bcd_pkg::*;

  logic       load;
  bcd_digit_t load_ten;
  bcd_digit_t load_one;
  logic       start;
  logic       pause;
  logic       en;
  bcd_digit_t count_ten;
  bcd_digit_t count_one;
  logic       busy;
  logic       done;
  logic       err;
  state_t     state;

  modport master (
    output load, load_ten, load_one, start, pause, en,
    input  count_ten, count_one, busy, done, err, state
  );

  modport slave (
    input  load, load_ten, load_one, start, pause, en,
    output count_ten, count_one, busy, done, err, state
  );

endinterface

// File: rtl/bcd_digit_dec.sv
// Single BCD digit decrementer.
//   digit      : current digit (0..9)
//   borrow_in  : 1 = subtract one from this digit
//   digit_next : resulting digit (0..9)
//   borrow_out : 1 when this digit wrapped 0 -> 9 and the next digit must
//                give up one
module bcd_digit_dec
  import bcd_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       borrow_in,
  output bcd_digit_t digit_next,
  output logic       borrow_out
);

  always_comb begin
    digit_next = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == 4'd0) begin
        digit_next = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        digit_next = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_down_counter.sv
// Two-digit BCD down counter with load, start/pause control and optional
// auto-reload.
//   clk   : sole clock, rising edge
//   reset : synchronous, active-low
//   bus   : bcd_down_counter_if.slave (requests in, count/status out)
// Request priority at each edge: reset > load > pause > start > en.
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input logic               clk,
  input logic               reset,
  bcd_down_counter_if.slave bus
);

  state_t     state;
  bcd_digit_t cnt_ten;
  bcd_digit_t cnt_one;
  bcd_digit_t rl_ten;
  bcd_digit_t rl_one;
  logic       done_q;
  logic       err_q;

  bcd_digit_t ones_next;
  bcd_digit_t tens_next;
  logic       ones_borrow;
  logic       tens_borrow;

  // Ones always decrements; its borrow ripples into the tens digit.
  bcd_digit_dec u_dec_one (
    .digit      (cnt_one),
    .borrow_in  (1'b1),
    .digit_next (ones_next),
    .borrow_out (ones_borrow)
  );

  bcd_digit_dec u_dec_ten (
    .digit      (cnt_ten),
    .borrow_in  (ones_borrow),
    .digit_next (tens_next),
    .borrow_out (tens_borrow)
  );

  logic load_ok;
  logic cnt_zero;
  logic cnt_last;
  logic rl_zero;

  assign load_ok  = is_bcd(bus.load_ten) && is_bcd(bus.load_one);
  assign cnt_zero = (cnt_ten == 4'd0) && (cnt_one == 4'd0);
  assign cnt_last = (cnt_ten == 4'd0) && (cnt_one == 4'd1);
  assign rl_zero  = (rl_ten == 4'd0) && (rl_one == 4'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt_ten <= 4'd0;
      cnt_one <= 4'd0;
      rl_ten  <= 4'd0;
      rl_one  <= 4'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.load) begin
        if (load_ok) begin
          cnt_ten <= bus.load_ten;
          cnt_one <= bus.load_one;
          rl_ten  <= bus.load_ten;
          rl_one  <= bus.load_one;
          state   <= ST_IDLE;
          err_q   <= 1'b0;
        end else begin
          err_q <= 1'b1;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (!bus.pause && bus.start && !cnt_zero) begin
              state <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (bus.pause) begin
              state <= ST_PAUSE;
            end else if (cnt_zero) begin
              // Only reachable with auto-reload: the cycle after done.
              cnt_ten <= rl_ten;
              cnt_one <= rl_one;
            end else if (bus.en && !tens_borrow) begin
              // tens_borrow would mean wrapping below 00; never taken.
              cnt_ten <= tens_next;
              cnt_one <= ones_next;
              if (cnt_last) begin
                done_q <= 1'b1;
                if (!AUTO_RELOAD || rl_zero) begin
                  state <= ST_DONE;
                end
              end
            end
          end
          ST_PAUSE: begin
            if (!bus.pause && bus.start) begin
              state <= ST_RUN;
            end
          end
          ST_DONE: begin
            state <= ST_DONE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.count_ten = cnt_ten;
  assign bus.count_one = cnt_one;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.state     = state;
  assign bus.busy      = (state == ST_RUN) || (state == ST_PAUSE);

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed bench for bcd_down_counter: one instance without and one with
// auto-reload, both sharing clk and reset.
module tb_bcd_down_counter;
  import bcd_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bcd_down_counter_if b0 ();
  bcd_down_counter_if b1 ();

  bcd_down_counter #(.AUTO_RELOAD(1'b0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b0.slave)
  );

  bcd_down_counter #(.AUTO_RELOAD(1'b1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1.slave)
  );

  // Advance one rising edge, then settle past it before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    b0.load = 1'b0; b0.load_ten = 4'd0; b0.load_one = 4'd0;
    b0.start = 1'b0; b0.pause = 1'b0; b0.en = 1'b0;
    b1.load = 1'b0; b1.load_ten = 4'd0; b1.load_one = 4'd0;
    b1.start = 1'b0; b1.pause = 1'b0; b1.en = 1'b0;
  endtask

  task automatic load0(input logic [3:0] t, input logic [3:0] o);
    b0.load = 1'b1; b0.load_ten = t; b0.load_one = o;
    step();
    b0.load = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    step();
    step();
    checks++;
    if ({b0.count_ten, b0.count_one} !== 8'h00) begin
      errors++; $display("FAIL reset_count got %h exp 00", {b0.count_ten, b0.count_one});
    end
    checks++;
    if ({b0.busy, b0.done, b0.err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b exp 000", {b0.busy, b0.done, b0.err});
    end
    checks++;
    if (b0.state !== ST_IDLE) begin
      errors++; $display("FAIL reset_state got %0d exp %0d", b0.state, ST_IDLE);
    end
    checks++;
    if ({b1.count_ten, b1.count_one, b1.busy, b1.done, b1.err} !== 11'h000) begin
      errors++; $display("FAIL reset_dut1 got %h exp 000", {b1.count_ten, b1.count_one, b1.busy, b1.done, b1.err});
    end
    reset = 1'b1;
  endtask

  task automatic test_count_down();
    logic [7:0] seq [12];
    seq = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
    load0(4'd1, 4'd2);
    checks++;
    if ({b0.count_ten, b0.count_one} !== 8'h12 || b0.state !== ST_IDLE) begin
      errors++; $display("FAIL cd_load got %h st %0d exp 12 st 0", {b0.count_ten, b0.count_one}, b0.state);
    end
    b0.start = 1'b1;
    step();
    b0.start = 1'b0;
    checks++;
    if (b0.state !== ST_RUN || b0.busy !== 1'b1) begin
      errors++; $display("FAIL cd_start got st %0d busy %b exp st 1 busy 1", b0.state, b0.busy);
    end
    b0.en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      checks++;
      if ({b0.count_ten, b0.count_one} !== seq[k]) begin
        errors++; $display("FAIL cd_count[%0d] got %h exp %h", k, {b0.count_ten, b0.count_one}, seq[k]);
      end
      checks++;
      if (b0.done !== (k == 11)) begin
        errors++; $display("FAIL cd_done[%0d] got %b exp %b", k, b0.done, (k == 11));
      end
    end
    checks++;
    if (b0.state !== ST_DONE || b0.busy !== 1'b0) begin
      errors++; $display("FAIL cd_end got st %0d busy %b exp st 3 busy 0", b0.state, b0.busy);
    end
    step();
    checks++;
    if (b0.done !== 1'b0 || {b0.count_ten, b0.count_one} !== 8'h00) begin
      errors++; $display("FAIL cd_after got done %b cnt %h exp done 0 cnt 00", b0.done, {b0.count_ten, b0.count_one});
    end
    b0.en = 1'b0;
  endtask

  task automatic test_err();
    load0(4'd1, 4'hA);
    checks++;
    if (b0.err !== 1'b1 || {b0.count_ten, b0.count_one} !== 8'h00 || b0.state !== ST_DONE) begin
      errors++; $display("FAIL err_reject got err %b cnt %h st %0d exp 1 00 3", b0.err, {b0.count_ten, b0.count_one}, b0.state);
    end
    step();
    checks++;
    if (b0.err !== 1'b1) begin
      errors++; $display("FAIL err_sticky got %b exp 1", b0.err);
    end
    load0(4'd0, 4'd5);
    checks++;
    if (b0.err !== 1'b0 || {b0.count_ten, b0.count_one} !== 8'h05 || b0.state !== ST_IDLE) begin
      errors++; $display("FAIL err_clear got err %b cnt %h st %0d exp 0 05 0", b0.err, {b0.count_ten, b0.count_one}, b0.state);
    end
  endtask

  task automatic test_en_hold();
    b0.start = 1'b1;
    step();
    b0.start = 1'b0;
    b0.en = 1'b0;
    step();
    step();
    checks++;
    if ({b0.count_ten, b0.count_one} !== 8'h05 || b0.state !== ST_RUN) begin
      errors++; $display("FAIL en_hold got cnt %h st %0d exp 05 1", {b0.count_ten, b0.count_one}, b0.state);
    end
  endtask

  task automatic test_pause();
    load0(4'd2, 4'd0);
    b0.start = 1'b1;
    step();
    b0.start = 1'b0;
    b0.en = 1'b1;
    step(); step(); step();
    checks++;
    if ({b0.count_ten, b0.count_one} !== 8'h17) begin
      errors++; $display("FAIL pause_pre got %h exp 17", {b0.count_ten, b0.count_one});
    end
    b0.pause = 1'b1;
    step();
    b0.pause = 1'b0;
    checks++;
    if (b0.state !== ST_PAUSE || b0.busy !== 1'b1 || {b0.count_ten, b0.count_one} !== 8'h17) begin
      errors++; $display("FAIL pause_enter got st %0d busy %b cnt %h exp 2 1 17", b0.state, b0.busy, {b0.count_ten, b0.count_one});
    end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (b0.state !== ST_PAUSE || {b0.count_ten, b0.count_one} !== 8'h17) begin
        errors++; $display("FAIL pause_hold[%0d] got st %0d cnt %h exp 2 17", k, b0.state, {b0.count_ten, b0.count_one});
      end
    end
    b0.pause = 1'b1;
    b0.start = 1'b1;
    step();
    checks++;
    if (b0.state !== ST_PAUSE) begin
      errors++; $display("FAIL pause_wins got st %0d exp 2", b0.state);
    end
    b0.pause = 1'b0;
    step();
    b0.start = 1'b0;
    checks++;
    if (b0.state !== ST_RUN || {b0.count_ten, b0.count_one} !== 8'h17) begin
      errors++; $display("FAIL pause_resume got st %0d cnt %h exp 1 17", b0.state, {b0.count_ten, b0.count_one});
    end
    step();
    checks++;
    if ({b0.count_ten, b0.count_one} !== 8'h16) begin
      errors++; $display("FAIL pause_next got %h exp 16", {b0.count_ten, b0.count_one});
    end
    b0.en = 1'b0;
  endtask

  task automatic test_auto_reload();
    logic [7:0] seq [8];
    logic       dn  [8];
    seq = '{8'h02, 8'h01, 8'h00, 8'h03, 8'h02, 8'h01, 8'h00, 8'h03};
    dn  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    b1.load = 1'b1; b1.load_ten = 4'd0; b1.load_one = 4'd3;
    step();
    b1.load = 1'b0;
    b1.start = 1'b1;
    step();
    b1.start = 1'b0;
    checks++;
    if ({b1.count_ten, b1.count_one} !== 8'h03 || b1.state !== ST_RUN) begin
      errors++; $display("FAIL ar_start got cnt %h st %0d exp 03 1", {b1.count_ten, b1.count_one}, b1.state);
    end
    b1.en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if ({b1.count_ten, b1.count_one} !== seq[k] || b1.done !== dn[k] || b1.state !== ST_RUN) begin
        errors++; $display("FAIL ar_seq[%0d] got cnt %h done %b st %0d exp %h %b 1", k, {b1.count_ten, b1.count_one}, b1.done, b1.state, seq[k], dn[k]);
      end
    end
    b1.en = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    load0(4'd5, 4'd0);
    b0.start = 1'b1;
    step();
    b0.start = 1'b0;
    b0.en = 1'b1;
    step(); step(); step();
    checks++;
    if ({b0.count_ten, b0.count_one} !== 8'h47 || b0.state !== ST_RUN) begin
      errors++; $display("FAIL rst_pre got cnt %h st %0d exp 47 1", {b0.count_ten, b0.count_one}, b0.state);
    end
    reset = 1'b0;
    b0.load = 1'b1; b0.load_ten = 4'd9; b0.load_one = 4'd9;
    b0.start = 1'b1;
    step();
    checks++;
    if ({b0.count_ten, b0.count_one} !== 8'h00 || b0.state !== ST_IDLE || {b0.busy, b0.done, b0.err} !== 3'b000) begin
      errors++; $display("FAIL rst_mid got cnt %h st %0d flags %b exp 00 0 000", {b0.count_ten, b0.count_one}, b0.state, {b0.busy, b0.done, b0.err});
    end
    reset = 1'b1;
    b0.load = 1'b0;
    step();
    checks++;
    if (b0.state !== ST_IDLE || {b0.count_ten, b0.count_one} !== 8'h00) begin
      errors++; $display("FAIL start_zero got st %0d cnt %h exp 0 00", b0.state, {b0.count_ten, b0.count_one});
    end
    b0.start = 1'b0;
    b0.en = 1'b0;
  endtask

  task automatic test_done_state();
    load0(4'd0, 4'd1);
    b0.start = 1'b1;
    step();
    b0.start = 1'b0;
    b0.en = 1'b1;
    step();
    checks++;
    if (b0.state !== ST_DONE || b0.done !== 1'b1 || {b0.count_ten, b0.count_one} !== 8'h00) begin
      errors++; $display("FAIL done_enter got st %0d done %b cnt %h exp 3 1 00", b0.state, b0.done, {b0.count_ten, b0.count_one});
    end
    b0.start = 1'b1;
    b0.pause = 1'b1;
    step();
    checks++;
    if (b0.state !== ST_DONE || b0.done !== 1'b0 || {b0.count_ten, b0.count_one} !== 8'h00) begin
      errors++; $display("FAIL done_ignore got st %0d done %b cnt %h exp 3 0 00", b0.state, b0.done, {b0.count_ten, b0.count_one});
    end
    b0.start = 1'b0;
    b0.pause = 1'b0;
    b0.en = 1'b0;
    load0(4'd1, 4'd0);
    checks++;
    if (b0.state !== ST_IDLE || b0.busy !== 1'b0 || {b0.count_ten, b0.count_one} !== 8'h10) begin
      errors++; $display("FAIL done_load got st %0d busy %b cnt %h exp 0 0 10", b0.state, b0.busy, {b0.count_ten, b0.count_one});
    end
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    test_reset();
    test_count_down();
    test_err();
    test_en_hold();
    test_pause();
    test_auto_reload();
    test_reset_mid_run();
    test_done_state();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
